// File: rtl/eight_bit_divider.sv
// rtl/eight_bit_divider.sv - sequential unsigned divider by repeated subtraction
module eight_bit_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    logic             r_ge_d;

    assign r_ge_d = (r_q >= d_q);
    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (!r_ge_d) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Result registers only move on entry to DONE, so they hold between completions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        r_q <= dividend;
                        d_q <= divisor;
                        q_q <= '0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (r_ge_d) begin
                        r_q <= r_q - d_q;
                        q_q <= q_q + ONE;
                    end else begin
                        quotient    <= q_q;
                        remainder   <= r_q;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eight_bit_divider.sv
// tb/tb_eight_bit_divider.sv - self-checking bench for eight_bit_divider
module tb_eight_bit_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int fails  = 0;

    eight_bit_divider #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    // Reference: quotient/remainder by plain arithmetic; done lands Q+2 cycles
    // after acceptance, or 1 cycle for a zero divisor.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        int ai, bi, exp_q, exp_r, exp_z, exp_lat, n, busy_gaps;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            exp_q = 255; exp_r = ai; exp_z = 1; exp_lat = 1;
        end else begin
            exp_q = ai / bi; exp_r = ai % bi; exp_z = 0; exp_lat = exp_q + 2;
        end
        wait_idle(tag);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        n = 0;
        busy_gaps = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1) busy_gaps++;
        end while (done !== 1'b1 && n < 300);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_busy_gaps"}, 32'(busy_gaps), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        check({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_z));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int n;
        int done_at[$];
        logic [7:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, div_by_zero, quotient, remainder}, 32'd0);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, "t1_100_7");
        run_op(8'd255, 8'd1, "t2_255_1");
        run_op(8'd255, 8'd255, "t2_255_255");
        run_op(8'd5, 8'd9, "t3_5_9");
        run_op(8'd0, 8'd3, "t3_0_3");
        run_op(8'd42, 8'd0, "t4_42_0");
        run_op(8'd10, 8'd3, "t4_10_3");

        // Start pulsed mid-operation with new operands must be ignored.
        wait_idle("t5");
        dividend = 8'd200; divisor = 8'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        dividend = 8'd9; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dividend = 8'd77; divisor = 8'd5;
        n = 6;
        done_at.delete();
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) done_at.push_back(n);
        end
        check("t5_done_count", 32'(done_at.size()), 32'd1);
        if (done_at.size() > 0) check("t5_latency", 32'(done_at[0]), 32'd22);
        check("t5_quotient", 32'(quotient), 32'd20);
        check("t5_remainder", 32'(remainder), 32'd0);

        // Start held high: second accept comes the cycle after DONE (30/7: Q=4).
        wait_idle("t5b");
        dividend = 8'd30; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        n = 0;
        done_at.delete();
        while (n < 13) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) done_at.push_back(n);
            if (n == 7) check("t5b_gap_busy", 32'(busy), 32'd0);
            if (n == 8) check("t5b_reaccept_busy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        check("t5b_done_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) begin
            check("t5b_first_done", 32'(done_at[0]), 32'd6);
            check("t5b_second_done", 32'(done_at[1]), 32'd13);
        end
        check("t5b_quotient", 32'(quotient), 32'd4);
        check("t5b_remainder", 32'(remainder), 32'd2);

        // Reset mid-operation abandons the divide with no done pulse.
        wait_idle("t6");
        dividend = 8'd250; divisor = 8'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (50) @(negedge clk);
        check("t6_busy_before_reset", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_reset", {busy, done, div_by_zero, quotient, remainder}, 32'd0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        rst_n = 1'b1;
        repeat (150) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        check("t6_no_done", 32'(n), 32'd0);
        run_op(8'd9, 8'd4, "t6_9_4");

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 40));
            run_op(ra, rb, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
